xdma_desc_byp_arbiter: RTL and testbench

- Shares one XDMA descriptor-bypass channel (C2H or H2C; one instance per direction) among NUM_REQ user-logic requesters.
- Grants requesters in round-robin order and drives the channel's load/ready handshake.
- Limits in-flight descriptors and routes each desc_done status pulse back to the requester that issued that descriptor.
- Sits between the BSV DMA engines and the xdma_0 bypass ports, in the user_clk domain.

---
 rtl/xdma_byp_pkg.sv | 24 ++
 rtl/byp_id_fifo.sv | 66 ++++++
 rtl/xdma_desc_byp_arbiter.sv | 155 +++++++++++++++
 tb/tb_xdma_desc_byp_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_byp_pkg.sv
// Shared definitions for the XDMA descriptor-bypass arbiter.
// Holds the bypass field widths, the desc_done status bit position, the
// descriptor payload struct and the arbiter FSM state encoding.
package xdma_byp_pkg;

  localparam int unsigned XDMA_ADDR_W       = 64;
  localparam int unsigned XDMA_LEN_W        = 28;
  localparam int unsigned XDMA_CTL_W        = 16;
  localparam int unsigned STS_DESC_DONE_BIT = 3;

  // One bypass descriptor as presented to dsc_byp_*
  typedef struct packed {
    logic [XDMA_ADDR_W-1:0] src;
    logic [XDMA_ADDR_W-1:0] dst;
    logic [XDMA_LEN_W-1:0]  len;
    logic [XDMA_CTL_W-1:0]  ctl;
  } byp_desc_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } byp_state_t;

endpackage

// File: rtl/byp_id_fifo.sv
// Synchronous FIFO holding the requester ID of every in-flight descriptor.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_push, i_data   enqueue an ID
//   i_pop            dequeue the head (ignored when empty)
//   o_head           current head entry
//   o_count          occupancy, 0..DEPTH
//   o_full, o_empty  occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module byp_id_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/xdma_desc_byp_arbiter.sv
// Round-robin arbiter sharing one XDMA descriptor-bypass channel among
// NUM_REQ requesters, with in-flight limiting and desc_done routing.
// Ports:
//   CLK, RST                      user clock, synchronous active-high reset
//   req_valid/req_ready           per-requester handshake (ready is combinational)
//   req_src/dst_addr, len, ctl    packed per-requester descriptor fields
//   done_valid, done_id           one-cycle completion routed to the issuer
//   byp_ready, byp_load, byp_*    XDMA dsc_byp_* channel
//   desc_done                     sts desc_done pulse from the channel
//   outstanding                   descriptors issued but not completed
//   err_spurious_done             sticky: desc_done with nothing in flight
module xdma_desc_byp_arbiter
  import xdma_byp_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned ID_W            = 2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*XDMA_ADDR_W-1:0]  req_src_addr,
  input  logic [NUM_REQ*XDMA_ADDR_W-1:0]  req_dst_addr,
  input  logic [NUM_REQ*XDMA_LEN_W-1:0]   req_len,
  input  logic [NUM_REQ*XDMA_CTL_W-1:0]   req_ctl,
  output logic                            done_valid,
  output logic [ID_W-1:0]                 done_id,
  input  logic                            byp_ready,
  output logic                            byp_load,
  output logic [XDMA_ADDR_W-1:0]          byp_src_addr,
  output logic [XDMA_ADDR_W-1:0]          byp_dst_addr,
  output logic [XDMA_LEN_W-1:0]           byp_len,
  output logic [XDMA_CTL_W-1:0]           byp_ctl,
  input  logic                            desc_done,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                            err_spurious_done
);

  byp_state_t      r_state;
  byp_desc_t       r_desc;
  byp_desc_t       w_desc;
  logic [ID_W-1:0] r_rr;
  logic [ID_W-1:0] r_winner;
  logic [ID_W-1:0] w_winner;
  logic [ID_W-1:0] w_head;
  logic            r_byp_load;
  logic            r_done_valid;
  logic [ID_W-1:0] r_done_id;
  logic            r_err;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;

  // First set request strictly after 'last', wrapping around
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W-1:0]    pick;
    logic               found;
    logic [NUM_REQ-1:0] sh;
    int unsigned        idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(last) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sh = v >> idx;
      if (!found && sh[0]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_winner  = rr_pick(req_valid, r_rr);
  // Full FIFO is the same condition as outstanding == MAX_OUTSTANDING
  assign w_grant   = !RST && (r_state == ST_IDLE) && (|req_valid) && !w_full;
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_winner) : '0;

  // Select the winner's fields out of the packed request buses
  always_comb begin
    w_desc     = '0;
    w_desc.src = XDMA_ADDR_W'(req_src_addr >> (32'(w_winner) * XDMA_ADDR_W));
    w_desc.dst = XDMA_ADDR_W'(req_dst_addr >> (32'(w_winner) * XDMA_ADDR_W));
    w_desc.len = XDMA_LEN_W'(req_len >> (32'(w_winner) * XDMA_LEN_W));
    w_desc.ctl = XDMA_CTL_W'(req_ctl >> (32'(w_winner) * XDMA_CTL_W));
  end

  assign w_push = r_byp_load && byp_ready;
  assign w_pop  = desc_done && !w_empty;

  byp_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_data  (r_winner),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (outstanding),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Grant/load FSM plus registered completion and error outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_rr         <= ID_W'(NUM_REQ - 1);
      r_winner     <= '0;
      r_desc       <= '0;
      r_byp_load   <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_done_valid <= w_pop;
      if (w_pop)                 r_done_id <= w_head;
      if (desc_done && w_empty)  r_err     <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_desc     <= w_desc;
            r_rr       <= w_winner;
            r_winner   <= w_winner;
            r_byp_load <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (byp_ready) begin
            r_byp_load <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign byp_load          = r_byp_load;
  assign byp_src_addr      = r_desc.src;
  assign byp_dst_addr      = r_desc.dst;
  assign byp_len           = r_desc.len;
  assign byp_ctl           = r_desc.ctl;
  assign done_valid        = r_done_valid;
  assign done_id           = r_done_id;
  assign err_spurious_done = r_err;

endmodule

// File: tb/tb_xdma_desc_byp_arbiter.sv
// Directed testbench for xdma_desc_byp_arbiter (NUM_REQ=4, MAX_OUTSTANDING=8).
module tb_xdma_desc_byp_arbiter;

  logic         CLK = 1'b0;
  logic         RST;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_src_addr;
  logic [255:0] req_dst_addr;
  logic [111:0] req_len;
  logic [63:0]  req_ctl;
  logic         done_valid;
  logic [1:0]   done_id;
  logic         byp_ready;
  logic         byp_load;
  logic [63:0]  byp_src_addr;
  logic [63:0]  byp_dst_addr;
  logic [27:0]  byp_len;
  logic [15:0]  byp_ctl;
  logic         desc_done;
  logic [3:0]   outstanding;
  logic         err_spurious_done;

  logic [63:0]  tb_src [4];
  logic [63:0]  tb_dst [4];
  logic [27:0]  tb_len [4];
  logic [15:0]  tb_ctl [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_src_addr[g*64 +: 64] = tb_src[g];
    assign req_dst_addr[g*64 +: 64] = tb_dst[g];
    assign req_len[g*28 +: 28]      = tb_len[g];
    assign req_ctl[g*16 +: 16]      = tb_ctl[g];
  end

  xdma_desc_byp_arbiter #(
    .NUM_REQ         (4),
    .MAX_OUTSTANDING (8),
    .ID_W            (2)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_src_addr      (req_src_addr),
    .req_dst_addr      (req_dst_addr),
    .req_len           (req_len),
    .req_ctl           (req_ctl),
    .done_valid        (done_valid),
    .done_id           (done_id),
    .byp_ready         (byp_ready),
    .byp_load          (byp_load),
    .byp_src_addr      (byp_src_addr),
    .byp_dst_addr      (byp_dst_addr),
    .byp_len           (byp_len),
    .byp_ctl           (byp_ctl),
    .desc_done         (desc_done),
    .outstanding       (outstanding),
    .err_spurious_done (err_spurious_done)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int rr_e;
  int drain_exp [7] = '{2, 3, 0, 1, 2, 3, 0};
  int ord_exp   [3] = '{2, 0, 3};

  initial begin
    RST       = 1'b1;
    req_valid = 4'hf;
    byp_ready = 1'b0;
    desc_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tb_src[i] = '0; tb_dst[i] = '0; tb_len[i] = '0; tb_ctl[i] = '0;
    end
    tick();
    tick();
    // Reset state
    check("rst_ready",       64'(req_ready), 64'd0);
    check("rst_byp_load",    64'(byp_load), 64'd0);
    check("rst_byp_src",     byp_src_addr, 64'd0);
    check("rst_done_valid",  64'(done_valid), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_err",         64'(err_spurious_done), 64'd0);
    req_valid = 4'h0;
    RST       = 1'b0;

    // Single request from requester 0
    tb_src[0] = 64'h1000; tb_dst[0] = 64'h2000; tb_len[0] = 28'd64; tb_ctl[0] = 16'h13;
    byp_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    check("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    check("t1_load", 64'(byp_load), 64'd1);
    check("t1_src",  byp_src_addr, 64'h1000);
    check("t1_dst",  byp_dst_addr, 64'h2000);
    check("t1_len",  64'(byp_len), 64'd64);
    check("t1_ctl",  64'(byp_ctl), 64'h13);
    tick();
    check("t1_load_drop", 64'(byp_load), 64'd0);
    check("t1_outst1",    64'(outstanding), 64'd1);
    desc_done = 1'b1;
    tick();
    desc_done = 1'b0;
    check("t1_done_valid", 64'(done_valid), 64'd1);
    check("t1_done_id",    64'(done_id), 64'd0);
    check("t1_outst0",     64'(outstanding), 64'd0);
    tick();
    check("t1_done_pulse", 64'(done_valid), 64'd0);

    // Fresh reset so the round-robin pointer restarts at NUM_REQ-1
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tb_src[i] = 64'h1000_0000 | 64'(i << 8);
      tb_dst[i] = 64'h2000_0000 | 64'(i << 8);
      tb_len[i] = 28'(i + 1);
      tb_ctl[i] = 16'(16'h10 + i);
    end
    req_valid = 4'hf;
    #1;
    // Round-robin: eight grants 0,1,2,3,0,1,2,3 which also fill the in-flight limit
    for (int k = 0; k < 8; k++) begin
      rr_e = k % 4;
      check("rr_ready", 64'(req_ready), 64'(4'b0001 << rr_e));
      tick();
      check("rr_load",     64'(byp_load), 64'd1);
      check("rr_src",      byp_src_addr, tb_src[rr_e]);
      check("rr_len",      64'(byp_len), 64'(tb_len[rr_e]));
      check("rr_no_ready", 64'(req_ready), 64'd0);
      tick();
    end
    check("full_outst", 64'(outstanding), 64'd8);
    check("full_ready", 64'(req_ready), 64'd0);
    tick();
    check("full_ready_hold", 64'(req_ready), 64'd0);
    check("full_outst_hold", 64'(outstanding), 64'd8);

    // One completion frees a slot; grant resumes right after
    desc_done = 1'b1;
    tick();
    desc_done = 1'b0;
    check("lim_done_valid", 64'(done_valid), 64'd1);
    check("lim_done_id",    64'(done_id), 64'd0);
    check("lim_outst7",     64'(outstanding), 64'd7);
    check("lim_ready",      64'(req_ready), 64'h1);
    byp_ready = 1'b0;
    tick();
    check("lim_load",   64'(byp_load), 64'd1);
    check("lim_src",    byp_src_addr, tb_src[0]);
    check("lim_outst",  64'(outstanding), 64'd7);
    // Transfer and completion in the same cycle
    desc_done = 1'b1;
    byp_ready = 1'b1;
    req_valid = 4'h0;
    tick();
    check("sim_outst",      64'(outstanding), 64'd7);
    check("sim_done_valid", 64'(done_valid), 64'd1);
    check("sim_done_id",    64'(done_id), 64'd1);
    check("sim_load_drop",  64'(byp_load), 64'd0);

    // Drain with back-to-back completions
    for (int k = 0; k < 7; k++) begin
      tick();
      check("drain_valid", 64'(done_valid), 64'd1);
      check("drain_id",    64'(done_id), 64'(drain_exp[k]));
    end
    desc_done = 1'b0;
    check("drain_outst", 64'(outstanding), 64'd0);
    tick();
    check("drain_end_valid", 64'(done_valid), 64'd0);
    check("drain_err",       64'(err_spurious_done), 64'd0);

    // Issue 2 (with 5 cycles of backpressure), then 0, then 3
    req_valid = 4'b0100;
    byp_ready = 1'b0;
    #1;
    check("ord_ready2", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b0001;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_load",     64'(byp_load), 64'd1);
      check("bp_src",      byp_src_addr, tb_src[2]);
      check("bp_ctl",      64'(byp_ctl), 64'(tb_ctl[2]));
      check("bp_no_ready", 64'(req_ready), 64'd0);
      tick();
    end
    check("bp_outst", 64'(outstanding), 64'd0);
    byp_ready = 1'b1;
    tick();
    check("bp_xfer_load",  64'(byp_load), 64'd0);
    check("bp_xfer_outst", 64'(outstanding), 64'd1);
    check("ord_ready0",    64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b1000;
    #1;
    check("ord_load0",   64'(byp_load), 64'd1);
    check("ord_src0",    byp_src_addr, tb_src[0]);
    check("ord_noready", 64'(req_ready), 64'd0);
    tick();
    check("ord_outst2", 64'(outstanding), 64'd2);
    check("ord_ready3", 64'(req_ready), 64'h8);
    tick();
    req_valid = 4'h0;
    check("ord_src3", byp_src_addr, tb_src[3]);
    tick();
    check("ord_outst3", 64'(outstanding), 64'd3);
    desc_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ord_valid", 64'(done_valid), 64'd1);
      check("ord_id",    64'(done_id), 64'(ord_exp[k]));
    end
    desc_done = 1'b0;
    tick();
    check("ord_end_valid", 64'(done_valid), 64'd0);
    check("ord_end_outst", 64'(outstanding), 64'd0);

    // Spurious completion sets a sticky error
    desc_done = 1'b1;
    tick();
    desc_done = 1'b0;
    check("spur_err",   64'(err_spurious_done), 64'd1);
    check("spur_valid", 64'(done_valid), 64'd0);
    check("spur_outst", 64'(outstanding), 64'd0);
    tick();
    tick();
    check("spur_sticky", 64'(err_spurious_done), 64'd1);

    // Reset while a descriptor is held in LOAD
    req_valid = 4'b0010;
    byp_ready = 1'b1;
    #1;
    tick();
    req_valid = 4'b0000;
    tick();
    check("rl_outst1", 64'(outstanding), 64'd1);
    req_valid = 4'b0010;
    byp_ready = 1'b0;
    tick();
    req_valid = 4'b0000;
    check("rl_load", 64'(byp_load), 64'd1);
    check("rl_src",  byp_src_addr, tb_src[1]);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rl_load_drop", 64'(byp_load), 64'd0);
    check("rl_outst0",    64'(outstanding), 64'd0);
    check("rl_err_clr",   64'(err_spurious_done), 64'd0);
    check("rl_src_clr",   byp_src_addr, 64'd0);

    // Orphaned completion after reset is flagged
    desc_done = 1'b1;
    tick();
    desc_done = 1'b0;
    check("orphan_err",   64'(err_spurious_done), 64'd1);
    check("orphan_valid", 64'(done_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
